// File: rtl/mcs4_rom_bank.sv
// mcs4_rom_bank: MCS-4 program-memory bank emulating NUM_ROMS i4001-style ROM chips
// on the 4004 instruction bus.
//
// Tracks the 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3), captures the 12-bit
// fetch address for external storage, drives OPR/OPA when the addressed chip belongs
// to this bank, and implements SRC/WRR/RDR per-chip 4-bit I/O ports.
//
// Ports:
//   sysclk     - sole clock, rising edge
//   reset_n    - asynchronous active-low reset
//   clk1_pad   - phase-1 level (sampled only)
//   clk2_pad   - phase-2 level; its falling edge ends the current phase
//   sync_pad   - high during X3, marks the next phase as A1
//   cmrom_pad  - CM-ROM from the CPU
//   clear_pad  - synchronous clear of the I/O output latches
//   data_in    - resolved data bus value
//   data_out   - value to drive onto the bus
//   data_oe    - drive enable for data_out
//   rom_addr   - {chip, addr_hi, addr_lo} to storage
//   rom_data   - storage word, valid one sysclk after rom_addr changes
//   io_in      - external I/O pin levels, 4 per chip
//   io_out     - I/O output latches masked by IO_OUTPUT
module mcs4_rom_bank #(
  parameter int unsigned             NUM_ROMS  = 4,
  parameter int unsigned             ROM_BASE  = 0,
  parameter logic [4*NUM_ROMS-1:0]   IO_OUTPUT = {NUM_ROMS{4'b1111}}
) (
  input  logic                  sysclk,
  input  logic                  reset_n,
  input  logic                  clk1_pad,
  input  logic                  clk2_pad,
  input  logic                  sync_pad,
  input  logic                  cmrom_pad,
  input  logic                  clear_pad,
  input  logic [3:0]            data_in,
  output logic [3:0]            data_out,
  output logic                  data_oe,
  output logic [11:0]           rom_addr,
  input  logic [7:0]            rom_data,
  input  logic [4*NUM_ROMS-1:0] io_in,
  output logic [4*NUM_ROMS-1:0] io_out
);

  localparam logic [4:0] NumRoms5 = 5'(NUM_ROMS);
  localparam logic [4:0] RomBase5 = 5'(ROM_BASE);

  typedef enum logic [3:0] {
    StUnsync, StA1, StA2, StA3, StM1, StM2, StX1, StX2, StX3
  } state_e;

  state_e                state_q, state_d;
  logic                  clk1_q, clk2_q;
  logic                  adv;
  logic [3:0]            addr_lo_q, addr_hi_q;
  logic [11:0]           rom_addr_q;
  logic [3:0]            io_opa_q, src_chip_q;
  logic                  io_cyc_q;
  logic [4*NUM_ROMS-1:0] latch_q, latch_d;
  logic [4:0]            chip_off, src_off;
  logic                  sel, src_sel;
  logic                  do_wrr, do_rdr;
  logic [3:0]            rdr_val;

  // clk1 is only observed, never used for timing.
  logic unused_clk1;
  assign unused_clk1 = clk1_q;

  // Phase ends on the sysclk where clk2 has just fallen.
  assign adv = clk2_q & ~clk2_pad;

  // Offsets wrap in 5 bits so a chip below ROM_BASE lands far out of range.
  assign chip_off = {1'b0, rom_addr_q[11:8]} - RomBase5;
  assign src_off  = {1'b0, src_chip_q} - RomBase5;
  assign sel      = chip_off < NumRoms5;
  assign src_sel  = src_off < NumRoms5;

  assign do_wrr = (state_q == StX2) && io_cyc_q && (io_opa_q == 4'h2) && src_sel;
  assign do_rdr = (state_q == StX2) && io_cyc_q && (io_opa_q == 4'hA) && src_sel;

  always_comb begin
    state_d = state_q;
    if (adv) begin
      if (sync_pad) begin
        state_d = StA1;
      end else begin
        case (state_q)
          StUnsync: state_d = StUnsync;
          StA1:     state_d = StA2;
          StA2:     state_d = StA3;
          StA3:     state_d = StM1;
          StM1:     state_d = StM2;
          StM2:     state_d = StX1;
          StX1:     state_d = StX2;
          StX2:     state_d = StX3;
          StX3:     state_d = StA1;
          default:  state_d = StUnsync;
        endcase
      end
    end
  end

  always_comb begin
    latch_d = latch_q;
    if (clear_pad) begin
      latch_d = '0;
    end else if (adv && do_wrr) begin
      for (int unsigned k = 0; k < NUM_ROMS; k++) begin
        if (src_off == 5'(k)) latch_d[4*k +: 4] = data_in & IO_OUTPUT[4*k +: 4];
      end
    end
  end

  // Output pins read back their latch, input pins read the external level.
  always_comb begin
    rdr_val = 4'h0;
    for (int unsigned k = 0; k < NUM_ROMS; k++) begin
      if (src_off == 5'(k)) begin
        rdr_val = (latch_q[4*k +: 4] & IO_OUTPUT[4*k +: 4]) |
                  (io_in[4*k +: 4] & ~IO_OUTPUT[4*k +: 4]);
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StUnsync;
      clk1_q     <= 1'b0;
      clk2_q     <= 1'b0;
      addr_lo_q  <= 4'h0;
      addr_hi_q  <= 4'h0;
      rom_addr_q <= 12'h000;
      io_opa_q   <= 4'h0;
      io_cyc_q   <= 1'b0;
      src_chip_q <= 4'h0;
      latch_q    <= '0;
    end else begin
      state_q <= state_d;
      clk1_q  <= clk1_pad;
      clk2_q  <= clk2_pad;
      latch_q <= latch_d;
      if (adv) begin
        case (state_q)
          StA1: addr_lo_q  <= data_in;
          StA2: addr_hi_q  <= data_in;
          StA3: rom_addr_q <= {data_in, addr_hi_q, addr_lo_q};
          StM2: begin
            // Any bank's fetch defines the I/O instruction, selected or not.
            io_opa_q <= data_in;
            io_cyc_q <= cmrom_pad;
          end
          StX2: if (cmrom_pad) src_chip_q <= data_in;
          default: ;
        endcase
      end
    end
  end

  // Drive is gated off by adv so the bus is released on the sysclk that ends the phase.
  always_comb begin
    data_oe  = 1'b0;
    data_out = 4'h0;
    if (!adv) begin
      if ((state_q == StM1) && sel) begin
        data_oe  = 1'b1;
        data_out = rom_data[7:4];
      end else if ((state_q == StM2) && sel) begin
        data_oe  = 1'b1;
        data_out = rom_data[3:0];
      end else if (do_rdr) begin
        data_oe  = 1'b1;
        data_out = rdr_val;
      end
    end
  end

  assign rom_addr = rom_addr_q;
  assign io_out   = latch_q & IO_OUTPUT;

endmodule

// File: doc/mcs4_rom_bank.md
Name: mcs4_rom_bank

Overview:
- Parametrised MCS-4 program-memory bank: emulates NUM_ROMS i4001-style ROM chips as a single unit on the 4004 instruction bus.
- Tracks the 8-phase instruction cycle: A1, A2, A3, M1, M2, X1, X2, X3.
- Presents a 12-bit address to external ROM storage, drives OPR/OPA onto the data bus when addressed, and implements SRC/WRR/RDR per-chip 4-bit I/O ports with per-pin direction.
- Successor to the single-chip ROM slice: adds multi-chip decode, base offset and a cycle-sync state machine.

Parameters:
- NUM_ROMS, 4: ROM chips emulated, 1..16.
- ROM_BASE, 0: chip number of the first chip. Chips occupy ROM_BASE..ROM_BASE+NUM_ROMS-1, which must be ≤15.
- IO_OUTPUT, {NUM_ROMS{4'b1111}}: 4*NUM_ROMS bits. Bit 1 = I/O pin is an output; bit 0 = input. Chip k uses bits [4k+3:4k].

Ports:
- sysclk, input, 1: sole clock, all logic on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- clk1_pad, input, 1: phase-1 level, synchronous to sysclk.
- clk2_pad, input, 1: phase-2 level, synchronous to sysclk. Its falling edge advances the phase.
- sync_pad, input, 1: high during X3; marks the next phase as A1.
- cmrom_pad, input, 1: CM-ROM from CPU.
- clear_pad, input, 1: synchronous clear of I/O output latches.
- data_in, input, 4: resolved data bus value.
- data_out, output, 4: value to drive on the bus.
- data_oe, output, 1: drive enable for data_out.
- rom_addr, output, 12: {chip, addr_hi, addr_lo} to storage.
- rom_data, input, 8: storage word; valid 1 sysclk after rom_addr changes.
- io_in, input, 4*NUM_ROMS: external pin levels.
- io_out, output, 4*NUM_ROMS: output latches, masked by IO_OUTPUT.

Behaviour:
- Phase-advance strobe: adv = clk2_d & ~clk2_pad, with clk2_d registered. clk1_pad is sampled for bench visibility only.
- States: UNSYNC, A1, A2, A3, M1, M2, X1, X2, X3.
  - Reset enters UNSYNC.
  - On adv: if sync_pad is 1, next state is A1 from any state. Otherwise advance in order, and X3 wraps to A1.
  - UNSYNC holds until it sees an adv with sync_pad=1.
- Address capture, each on the adv that ends the phase:
  - A1 latches addr_lo = data_in.
  - A2 latches addr_hi.
  - A3 latches chip.
- rom_addr updates at the end of A3 and holds until the next A3.
- sel = (chip - ROM_BASE) < NUM_ROMS, evaluated as an unsigned 5-bit compare.
- Data drive:
  - During M1 with sel: data_oe=1, data_out=rom_data[7:4].
  - During M2 with sel: data_oe=1, data_out=rom_data[3:0].
  - data_oe=1 only in those two phases, or during RDR X2. It deasserts in the same sysclk as the adv that ends the phase.
- I/O decode:
  - End of M2: latch io_opa = data_in and io_cyc = cmrom_pad. This applies whether or not sel, because any bank's fetch counts.
  - SRC: end of X2 with cmrom_pad=1 latches src_chip = data_in. The X3 nibble is ignored. src_chip persists until the next SRC.
  - WRR (io_cyc, io_opa=4'h2): end of X2, if src_chip is in range, sets latch[src_chip-ROM_BASE] = data_in & mask.
  - RDR (io_cyc, io_opa=4'hA): during X2, if src_chip is in range, data_oe=1 and data_out = (latch & mask) | (io_in & ~mask) for that chip.
  - Out-of-range src_chip: no WRR effect, no RDR drive.
- io_out = latch & IO_OUTPUT at all times.
- clear_pad=1 zeroes all latches. It has priority over a WRR in the same sysclk.
- Reset values: data_out=0, data_oe=0, rom_addr=0, io_out=0, src_chip=0, io_opa=0, io_cyc=0, state=UNSYNC.
- Reset mid-cycle aborts any drive immediately (asynchronous) and forces resync.
- sync_pad asserted outside X3 forces realignment; a drive in progress stops at that adv.

Test Plan:
- Reset then sync; bus A1=4'h3, A2=4'h2, A3=4'h1, rom_data=8'hD5, NUM_ROMS=4, ROM_BASE=0 → rom_addr=12'h123; M1 drives 4'hD; M2 drives 4'h5; data_oe low elsewhere.
- A3=4'h7 with NUM_ROMS=4 → data_oe stays 0 for the whole cycle; rom_addr still 12'h7xx.
- Cycle 1: SRC with cmrom_pad=1 in X2, data=4'h2. Cycle 2: M2 OPA=4'h2, cmrom_pad=1, X2 data=4'h9. → io_out[11:8]=4'h9; other chips unchanged.
- IO_OUTPUT chip 1 = 4'b0011, latch written 4'hF, io_in[7:4]=4'b1000, then RDR with src_chip=1 → X2 drives 4'hB; io_out[7:4]=4'h3.
- clear_pad pulse in the same sysclk as a WRR end → io_out all 0.
- reset_n low during M1 with data_oe=1 → data_oe=0 at once; no drive until sync is seen again; sync_pad pulsed at M1 → next phase is A1.
